// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory sides of the shared memory port.
// Ports: if_* (fetch requester), d_* (data requester), mem_* (memory side).
// slave = arbiter view, master = environment view (requesters plus memory model).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_data;
    logic              if_done;

    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        output if_data, if_done, d_rdata, d_done,
               mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        input  if_data, if_done, d_rdata, d_done,
               mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between fetch (I) and data (D).
// Latency: request seen in IDLE at t -> mem_en at t+1 -> done/data at t+MEM_LAT+2.
// Backpressure: requesters hold req until done; pipeline stalls on req & ~done.
// Ports: clk, rst (sync, active-high), bus (mem_port_arbiter_if.slave).
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.slave     bus
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic { IDLE, BUSY } state_t;
    typedef enum logic { OWN_I, OWN_D } owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, last_grant_q, grant_sel;
    logic              grant_vld;
    logic              if_elig, d_elig;
    logic [CNT_W-1:0]  cnt_q;

    logic [DATA_W-1:0] if_data_q, d_rdata_q, mem_wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              if_done_q, d_done_q, mem_en_q, mem_wr_q;

    // Next state and grant decision. A requester is ignored in its own done
    // cycle so it gets one cycle to present its next address.
    always_comb begin
        state_d   = state_q;
        grant_vld = 1'b0;
        grant_sel = OWN_I;
        if_elig   = bus.if_req & ~if_done_q;
        d_elig    = bus.d_req & ~d_done_q;
        case (state_q)
            IDLE: begin
                if (if_elig || d_elig) begin
                    grant_vld = 1'b1;
                    state_d   = BUSY;
                    // D wins ties unless it won the previous grant.
                    if (d_elig && !(if_elig && last_grant_q == OWN_D))
                        grant_sel = OWN_D;
                end
            end
            BUSY: begin
                if (cnt_q == '0)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= OWN_I;
            last_grant_q <= OWN_I;
            cnt_q        <= '0;
            if_data_q    <= '0;
            d_rdata_q    <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_done_q    <= 1'b0;
            d_done_q     <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
        end else begin
            mem_en_q  <= 1'b0;
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            if (grant_vld) begin
                owner_q      <= grant_sel;
                last_grant_q <= grant_sel;
                mem_en_q     <= 1'b1;
                cnt_q        <= CNT_W'(MEM_LAT);
                if (grant_sel == OWN_D) begin
                    mem_addr_q  <= bus.d_addr;
                    mem_wr_q    <= bus.d_wr;
                    mem_wdata_q <= bus.d_wdata;
                end else begin
                    mem_addr_q  <= bus.if_addr;
                    mem_wr_q    <= 1'b0;
                end
            end else if (state_q == BUSY) begin
                if (cnt_q == '0) begin
                    // Read data is valid in this cycle; hand it to the owner.
                    if (owner_q == OWN_I) begin
                        if_data_q <= bus.mem_rdata;
                        if_done_q <= 1'b1;
                    end else begin
                        if (!mem_wr_q)
                            d_rdata_q <= bus.mem_rdata;
                        d_done_q <= 1'b1;
                    end
                end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
        end
    end

    assign bus.if_data   = if_data_q;
    assign bus.if_done   = if_done_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_done    = d_done_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a fixed-latency memory model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: requests held until done, dropped in the done cycle.
module tb_mem_port_arbiter;
    localparam int MEM_LAT = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(MEM_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory contents for the addresses the bench uses.
    function automatic logic [15:0] mem_val(input logic [15:0] a);
        case (a)
            16'h0002: return 16'hA5A5;
            16'h0004: return 16'hC3C3;
            16'h0010: return 16'h5A5A;
            default:  return a ^ 16'hBEEF;
        endcase
    endfunction

    // Read data appears exactly MEM_LAT cycles after mem_en; junk otherwise.
    logic [MEM_LAT-1:0] rd_vld = '0;
    logic [15:0]        rd_addr [MEM_LAT];
    always @(posedge clk) begin
        rd_vld     <= {rd_vld[MEM_LAT-2:0], bus.mem_en & ~bus.mem_wr};
        rd_addr[0] <= bus.mem_addr;
        for (int k = 1; k < MEM_LAT; k++)
            rd_addr[k] <= rd_addr[k-1];
    end
    assign bus.mem_rdata = rd_vld[MEM_LAT-1] ? mem_val(rd_addr[MEM_LAT-1]) : 16'hDEAD;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_data"},   bus.if_data,   0);
        chk({tag, "_d_rdata"},   bus.d_rdata,   0);
        chk({tag, "_mem_addr"},  bus.mem_addr,  0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_if_done"},   bus.if_done,   0);
        chk({tag, "_d_done"},    bus.d_done,    0);
        chk({tag, "_mem_en"},    bus.mem_en,    0);
        chk({tag, "_mem_wr"},    bus.mem_wr,    0);
    endtask

    initial begin
        int n_en;
        int last_en;

        // Reset with both requests pending.
        rst         = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0004;
        bus.d_req   = 1'b1;
        bus.d_wr    = 1'b0;
        bus.d_addr  = 16'h0010;
        bus.d_wdata = 16'h0000;
        tick(1);
        chk_all_zero("rst1");
        tick(1);
        chk_all_zero("rst2");
        rst = 1'b0;

        // Simultaneous: D first, then I.
        tick(1);
        chk("simul_d_en",   bus.mem_en,   1);
        chk("simul_d_addr", bus.mem_addr, 16'h0010);
        chk("simul_d_wr",   bus.mem_wr,   0);
        tick(1);
        chk("simul_en_pulse", bus.mem_en, 0);
        tick(3);
        chk("simul_d_early", bus.d_done, 0);
        tick(1);
        chk("simul_d_done",  bus.d_done,  1);
        chk("simul_d_rdata", bus.d_rdata, 16'h5A5A);
        chk("simul_if_quiet", bus.if_done, 0);
        tick(1);
        chk("simul_i_en",   bus.mem_en,   1);
        chk("simul_i_addr", bus.mem_addr, 16'h0004);
        chk("simul_d_pulse", bus.d_done,  0);
        tick(4);
        chk("simul_i_early", bus.if_done, 0);
        tick(1);
        chk("simul_i_done", bus.if_done, 1);
        chk("simul_i_data", bus.if_data, 16'hC3C3);

        // Continuous contention: strict alternation, one strobe per 6 cycles.
        n_en    = 0;
        last_en = 7;
        for (int cyc = 13; cyc < 73; cyc++) begin
            tick(1);
            if (bus.mem_en) begin
                chk("cont_owner", bus.mem_addr, (n_en % 2 == 0) ? 16'h0010 : 16'h0004);
                chk("cont_gap", cyc - last_en, 6);
                last_en = cyc;
                n_en++;
            end
        end
        chk("cont_count", n_en, 10);
        chk("cont_last_i_done", bus.if_done, 1);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        tick(1);
        chk("cont_idle_en", bus.mem_en, 0);

        // Single fetch.
        bus.if_addr = 16'h0002;
        bus.if_req  = 1'b1;
        tick(1);
        chk("fetch_en",   bus.mem_en,   1);
        chk("fetch_addr", bus.mem_addr, 16'h0002);
        chk("fetch_wr",   bus.mem_wr,   0);
        tick(4);
        chk("fetch_early", bus.if_done, 0);
        tick(1);
        chk("fetch_done", bus.if_done, 1);
        chk("fetch_data", bus.if_data, 16'hA5A5);
        bus.if_req = 1'b0;
        tick(1);
        chk("fetch_pulse", bus.if_done, 0);
        chk("fetch_hold",  bus.if_data, 16'hA5A5);

        // Data write; command fields change while busy.
        bus.d_wr    = 1'b1;
        bus.d_addr  = 16'h0010;
        bus.d_wdata = 16'h1234;
        bus.d_req   = 1'b1;
        tick(1);
        chk("wr_en",    bus.mem_en,    1);
        chk("wr_wr",    bus.mem_wr,    1);
        chk("wr_addr",  bus.mem_addr,  16'h0010);
        chk("wr_wdata", bus.mem_wdata, 16'h1234);
        bus.d_addr  = 16'h0099;
        bus.d_wdata = 16'hFFFF;
        bus.d_wr    = 1'b0;
        tick(1);
        chk("wr_en_pulse",  bus.mem_en,    0);
        chk("wr_addr_held", bus.mem_addr,  16'h0010);
        chk("wr_data_held", bus.mem_wdata, 16'h1234);
        tick(3);
        chk("wr_early", bus.d_done, 0);
        tick(1);
        chk("wr_done",   bus.d_done,  1);
        chk("wr_rdata",  bus.d_rdata, 16'h5A5A);
        bus.d_req = 1'b0;
        tick(1);
        chk("wr_pulse", bus.d_done, 0);
        chk("wr_idle",  bus.mem_en, 0);

        // Fetch aborted by reset at E+2, then a fresh fetch.
        bus.if_addr = 16'h0002;
        bus.if_req  = 1'b1;
        tick(1);
        chk("abort_en",    bus.mem_en,    1);
        chk("abort_wdata", bus.mem_wdata, 16'h1234);
        tick(2);
        rst = 1'b1;
        tick(1);
        chk_all_zero("abort");
        rst         = 1'b0;
        bus.if_addr = 16'h0004;
        tick(1);
        chk("refetch_en",   bus.mem_en,   1);
        chk("refetch_addr", bus.mem_addr, 16'h0004);
        tick(1);
        chk("abort_no_done", bus.if_done, 0);
        tick(3);
        chk("refetch_early", bus.if_done, 0);
        tick(1);
        chk("refetch_done", bus.if_done, 1);
        chk("refetch_data", bus.if_data, 16'hC3C3);
        bus.if_req = 1'b0;
        tick(1);
        chk("refetch_pulse", bus.if_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
